// File: rtl/dds_cfg_pkg.sv
// -----------------------------------------------------------------------------
// dds_cfg_pkg
// Shared types for the chirp DDS configuration path: FSM state encoding,
// default word widths, the freq/step/rate parameter triple and the two-way
// arbitration helper used by dds_cfg_arb.
// -----------------------------------------------------------------------------
package dds_cfg_pkg;

    localparam int DDS_W_FREQ_DEF = 48;
    localparam int DDS_W_RATE_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ_HI,
        REQ_LO,
        START,
        ABORT
    } state_t;

    // One complete chirp parameter set at the default widths.
    typedef struct packed {
        logic [DDS_W_FREQ_DEF-1:0] freq;
        logic [DDS_W_FREQ_DEF-1:0] step;
        logic [DDS_W_RATE_DEF-1:0] rate;
    } dds_params_t;

    // Winner index for two requesters. `pref` only matters when both are
    // requesting; a lone requester always wins. Result is meaningless when
    // neither requests, so callers must qualify it with req0 | req1.
    function automatic logic arb_pick(input logic req0, input logic req1,
                                      input logic pref);
        if (req0 && req1) begin
            return pref;
        end
        return !req0;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// STAGES-deep single-bit synchronizer for bringing a level from another clock
// domain into clk. Cleared by asynchronous active-low reset.
//
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset
//   i_d    in   asynchronous level
//   o_q    out  i_d after STAGES flops of clk
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // NOTE: every clocked register uses non-blocking (<=) assignment so all
    // flops sample their inputs from before the edge, independent of the
    // order in which the simulator evaluates the blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dds_cfg_arb.sv
// -----------------------------------------------------------------------------
// dds_cfg_arb
// Arbitrates two chirp parameter sources (req0: real-time synchronizer,
// req1: calibration/test) for the single DDS, runs a 4-phase REQ/ACK transfer
// of the captured words into the DDS clock domain and then issues a one-cycle
// DDS_start strobe. Each handshake phase is bounded by TO_CYCLES; on timeout
// REQ is withdrawn and the transfer completes with err=1 and no DDS_start.
//
// Ports:
//   CLK                 in   48 MHz system clock
//   rst_n               in   asynchronous active-low reset
//   req0 / req1         in   level requests, held until done
//   freq0/1, step0/1    in   W_FREQ start frequency / step words
//   rate0/1             in   W_RATE step rate words
//   done0 / done1       out  one-cycle completion pulse per requester
//   err                 out  qualifies done: 1 = transfer timed out
//   busy                out  high in every state except IDLE
//   DDS_freq            out  captured frequency word
//   DDS_delta_freq      out  captured step word
//   DDS_delta_rate      out  captured rate word
//   REQ                 out  handshake request to the DDS domain
//   ACK                 in   asynchronous acknowledge from the DDS domain
//   DDS_start           out  one-cycle start strobe
//
// Build option:
//   DDS_CFG_ARB_RR_EN   defined: two-way round-robin between req0 and req1.
//                       undefined: fixed priority, req0 over req1.
// -----------------------------------------------------------------------------
module dds_cfg_arb
    import dds_cfg_pkg::*;
#(
    parameter int W_FREQ      = DDS_W_FREQ_DEF,
    parameter int W_RATE      = DDS_W_RATE_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TO_CYCLES   = 1024
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [W_FREQ-1:0] freq0,
    input  logic [W_FREQ-1:0] freq1,
    input  logic [W_FREQ-1:0] step0,
    input  logic [W_FREQ-1:0] step1,
    input  logic [W_RATE-1:0] rate0,
    input  logic [W_RATE-1:0] rate1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic              busy,
    output logic [W_FREQ-1:0] DDS_freq,
    output logic [W_FREQ-1:0] DDS_delta_freq,
    output logic [W_RATE-1:0] DDS_delta_rate,
    output logic              REQ,
    input  logic              ACK,
    output logic              DDS_start
);

    localparam int               W_CNT    = $clog2(TO_CYCLES);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TO_CYCLES - 1);

    state_t            r_state;
    logic              r_gsel;
    logic [W_CNT-1:0]  r_cnt;
    logic              r_req;
    logic              r_start;
    logic              r_done0;
    logic              r_done1;
    logic              r_err;
    logic              r_busy;
    logic [W_FREQ-1:0] r_freq;
    logic [W_FREQ-1:0] r_step;
    logic [W_RATE-1:0] r_rate;

    logic              w_ack_s;
    logic              w_pref;
    logic              w_win;
    logic              w_done_pulse;

    // ACK is only ever used in its synchronized form.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (CLK),
        .rst_n (rst_n),
        .i_d   (ACK),
        .o_q   (w_ack_s)
    );

`ifdef DDS_CFG_ARB_RR_EN
    logic r_ptr;

    // Preference flips to the other requester after every completion,
    // successful or timed out. r_gsel is still the served requester here
    // because no capture happens during a done cycle.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_done_pulse) begin
            r_ptr <= ~r_gsel;
        end
    end

    assign w_pref = r_ptr;
`else
    assign w_pref = 1'b0;
`endif

    assign w_win        = arb_pick(req0, req1, w_pref);
    assign w_done_pulse = r_done0 | r_done1;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gsel  <= 1'b0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_start <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_freq  <= '0;
            r_step  <= '0;
            r_rate  <= '0;
        end else begin
            // Pulse outputs are low unless the transition below raises them.
            r_start <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    // After an abort the done pulse lands in IDLE; holding off
                    // for that cycle gives the requester the same one-cycle
                    // window to drop req as after a normal START.
                    if ((req0 || req1) && !w_done_pulse) begin
                        r_freq  <= w_win ? freq1 : freq0;
                        r_step  <= w_win ? step1 : step0;
                        r_rate  <= w_win ? rate1 : rate0;
                        r_gsel  <= w_win;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= REQ_HI;
                    end
                end

                REQ_HI: begin
                    // First REQ_HI cycle raises REQ; the timeout then counts
                    // cycles with REQ actually high. Requiring r_req means a
                    // stale high ACK still sees REQ asserted before passing.
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= REQ_LO;
                    end else if (r_cnt == CNT_LAST) begin
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ABORT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                REQ_LO: begin
                    if (!w_ack_s) begin
                        r_start <= 1'b1;
                        r_done0 <= ~r_gsel;
                        r_done1 <= r_gsel;
                        r_state <= START;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ABORT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                START: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                ABORT: begin
                    // Completes with err once ACK is low or its own limit runs
                    // out, whichever comes first.
                    if (!w_ack_s || (r_cnt == CNT_LAST)) begin
                        r_done0 <= ~r_gsel;
                        r_done1 <= r_gsel;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign REQ            = r_req;
    assign DDS_start      = r_start;
    assign done0          = r_done0;
    assign done1          = r_done1;
    assign err            = r_err;
    assign busy           = r_busy;
    assign DDS_freq       = r_freq;
    assign DDS_delta_freq = r_step;
    assign DDS_delta_rate = r_rate;

endmodule

// File: tb/tb_dds_cfg_arb.sv
// -----------------------------------------------------------------------------
// tb_dds_cfg_arb
// Directed bench for dds_cfg_arb with TO_CYCLES=16. A DDS-side responder model
// drives ACK either with a 3-cycle delay, as an ideal echo of REQ, or tied low.
// -----------------------------------------------------------------------------
module tb_dds_cfg_arb;
    import dds_cfg_pkg::*;

    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [47:0] freq0 = '0, freq1 = '0, step0 = '0, step1 = '0;
    logic [31:0] rate0 = '0, rate1 = '0;
    logic        done0, done1, err, busy, REQ, ACK, DDS_start;
    logic [47:0] DDS_freq, DDS_delta_freq;
    logic [31:0] DDS_delta_rate;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum int {RESP_DELAY, RESP_IDEAL, RESP_TIED0} resp_t;
    resp_t resp_mode = RESP_DELAY;
    logic  ack_r = 1'b0;
    int    resp_hi = 0;
    int    resp_lo = 0;

    int    n_start = 0;
    logic  both_done = 1'b0;
    logic  exp_ptr = 1'b0;

    always #5 CLK = ~CLK;

    dds_cfg_arb #(
        .W_FREQ      (48),
        .W_RATE      (32),
        .SYNC_STAGES (2),
        .TO_CYCLES   (TO)
    ) dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .req0           (req0),
        .req1           (req1),
        .freq0          (freq0),
        .freq1          (freq1),
        .step0          (step0),
        .step1          (step1),
        .rate0          (rate0),
        .rate1          (rate1),
        .done0          (done0),
        .done1          (done1),
        .err            (err),
        .busy           (busy),
        .DDS_freq       (DDS_freq),
        .DDS_delta_freq (DDS_delta_freq),
        .DDS_delta_rate (DDS_delta_rate),
        .REQ            (REQ),
        .ACK            (ACK),
        .DDS_start      (DDS_start)
    );

    assign ACK = (resp_mode == RESP_IDEAL) ? REQ : ack_r;

    // Delayed responder: ACK follows REQ 3 cycles later in both directions.
    always @(negedge CLK) begin
        if (resp_mode != RESP_DELAY) begin
            ack_r   = 1'b0;
            resp_hi = 0;
            resp_lo = 0;
        end else if (!ack_r) begin
            if (REQ) begin
                resp_hi++;
                if (resp_hi == 3) begin
                    ack_r   = 1'b1;
                    resp_hi = 0;
                end
            end else begin
                resp_hi = 0;
            end
        end else begin
            if (!REQ) begin
                resp_lo++;
                if (resp_lo == 3) begin
                    ack_r   = 1'b0;
                    resp_lo = 0;
                end
            end else begin
                resp_lo = 0;
            end
        end
    end

    always @(posedge CLK) begin
        if (DDS_start) n_start++;
        if (done0 && done1) both_done = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int idx, input dds_params_t p);
        if (idx == 0) begin
            freq0 = p.freq; step0 = p.step; rate0 = p.rate;
        end else begin
            freq1 = p.freq; step1 = p.step; rate1 = p.rate;
        end
    endtask

    function automatic int exp_win(input logic r0, input logic r1);
`ifdef DDS_CFG_ARB_RR_EN
        if (r0 && r1) return exp_ptr ? 1 : 0;
`endif
        return r0 ? 0 : 1;
    endfunction

    task automatic note_grant(input int w);
        exp_ptr = (w == 0);
    endtask

    task automatic wait_done(input string tag, input int budget,
                             output int idx, output logic e);
        logic seen;
        seen = 1'b0;
        idx  = -1;
        e    = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge CLK);
            if (done0 || done1) begin
                seen = 1'b1;
                idx  = done1 ? 1 : 0;
                e    = err;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        dds_params_t p, pa, pb;
        int   idx, s0, rise, lat, hi, w, first, second;
        logic e, seen;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_REQ", 64'(REQ), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(DDS_start), 64'd0);
        check("rst_done", 64'({done1, done0, err}), 64'd0);
        check("rst_words", 64'(DDS_freq | DDS_delta_freq | 48'(DDS_delta_rate)), 64'd0);
        rst_n = 1'b1;
        @(negedge CLK);

        // T1: single req0, 3-cycle responder
        p = '{freq: 48'd43980465111040, step: 48'd2932031, rate: 32'd1};
        set_src(0, p);
        s0   = n_start;
        req0 = 1'b1;
        wait_done("t1", 200, idx, e);
        req0 = 1'b0;
        check("t1_idx", 64'(idx), 64'd0);
        check("t1_err", 64'(e), 64'd0);
        check("t1_freq", 64'(DDS_freq), 64'd43980465111040);
        check("t1_step", 64'(DDS_delta_freq), 64'd2932031);
        check("t1_rate", 64'(DDS_delta_rate), 64'd1);
        note_grant(0);
        @(negedge CLK);
        check("t1_done_width", 64'(done0), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_starts", 64'(n_start - s0), 64'd1);

        // T2: ideal responder, REQ rise and start latency
        resp_mode = RESP_IDEAL;
        p = '{freq: 48'h0000_1234_5678, step: 48'h0000_0000_0100, rate: 32'd7};
        set_src(0, p);
        rise = 0;
        lat  = 0;
        req0 = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge CLK);
            if (REQ && rise == 0) rise = k;
            if (DDS_start) lat = k;
        end
        check("t2_req_rise", 64'(rise), 64'd2);
        check("t2_latency", 64'(lat), 64'd8);
        check("t2_done0", 64'(done0), 64'd1);
        req0 = 1'b0;
        note_grant(0);
        @(negedge CLK);
        check("t2_idle", 64'(busy), 64'd0);
        resp_mode = RESP_DELAY;
        @(negedge CLK);

        // T3: both requesters rise together
        pa = '{freq: 48'h1111_2222_3333, step: 48'h0000_0000_0044, rate: 32'h55};
        pb = '{freq: 48'h6666_7777_8888, step: 48'h0000_0000_0099, rate: 32'hAA};
        set_src(0, pa);
        set_src(1, pb);
        s0     = n_start;
        first  = exp_win(1'b1, 1'b1);
        second = 1 - first;
        req0   = 1'b1;
        req1   = 1'b1;
        wait_done("t3a", 200, idx, e);
        if (first == 0) req0 = 1'b0; else req1 = 1'b0;
        check("t3a_idx", 64'(idx), 64'(first));
        check("t3a_err", 64'(e), 64'd0);
        check("t3a_freq", 64'(DDS_freq), (first == 0) ? 64'(pa.freq) : 64'(pb.freq));
        note_grant(first);
        wait_done("t3b", 200, idx, e);
        req0 = 1'b0;
        req1 = 1'b0;
        check("t3b_idx", 64'(idx), 64'(second));
        check("t3b_freq", 64'(DDS_freq), (second == 0) ? 64'(pa.freq) : 64'(pb.freq));
        check("t3b_rate", 64'(DDS_delta_rate), (second == 0) ? 64'(pa.rate) : 64'(pb.rate));
        note_grant(second);
        @(negedge CLK);
        check("t3_starts", 64'(n_start - s0), 64'd2);

        // T4: ACK tied low, timeout
        resp_mode = RESP_TIED0;
        p = '{freq: 48'h0000_00AB_CDEF, step: 48'h0000_0000_0002, rate: 32'd3};
        set_src(0, p);
        s0   = n_start;
        hi   = 0;
        seen = 1'b0;
        idx  = -1;
        e    = 1'b0;
        req0 = 1'b1;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge CLK);
            if (REQ) hi++;
            if (done0 || done1) begin
                seen = 1'b1;
                idx  = done1 ? 1 : 0;
                e    = err;
            end
        end
        req0 = 1'b0;
        check("t4_done_seen", 64'(seen), 64'd1);
        check("t4_req_cycles", 64'(hi), 64'(TO));
        check("t4_idx", 64'(idx), 64'd0);
        check("t4_err", 64'(e), 64'd1);
        note_grant(0);
        @(negedge CLK);
        check("t4_no_start", 64'(n_start - s0), 64'd0);
        check("t4_idle", 64'({busy, REQ}), 64'd0);
        resp_mode = RESP_DELAY;
        @(negedge CLK);

        // T5: reset while REQ is high
        p = '{freq: 48'h0A0B_0C0D_0E0F, step: 48'h0000_0000_1000, rate: 32'd9};
        set_src(0, p);
        req0 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CLK);
            if (REQ) seen = 1'b1;
        end
        check("t5_in_req_hi", 64'(REQ), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_req_busy", 64'({REQ, busy}), 64'd0);
        check("t5_rst_freq", 64'(DDS_freq), 64'd0);
        check("t5_rst_step_rate", 64'(DDS_delta_freq | 48'(DDS_delta_rate)), 64'd0);
        exp_ptr = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        wait_done("t5", 200, idx, e);
        req0 = 1'b0;
        check("t5_idx", 64'(idx), 64'd0);
        check("t5_err", 64'(e), 64'd0);
        check("t5_freq", 64'(DDS_freq), 64'(p.freq));
        note_grant(0);
        @(negedge CLK);

        // T6: parameters change after grant
        p = '{freq: 48'h0000_5555_AAAA, step: 48'h0000_0000_0777, rate: 32'd11};
        set_src(0, p);
        req0 = 1'b1;
        repeat (2) @(negedge CLK);
        freq0 = 48'hDEAD_BEEF_0001;
        step0 = 48'h0000_0000_0001;
        wait_done("t6", 200, idx, e);
        req0 = 1'b0;
        check("t6_freq_held", 64'(DDS_freq), 64'(p.freq));
        check("t6_step_held", 64'(DDS_delta_freq), 64'(p.step));
        note_grant(0);
        @(negedge CLK);

        // T7: both held high for four grants
        pa = '{freq: 48'h0000_0000_A000, step: 48'h0000_0000_000A, rate: 32'hA};
        pb = '{freq: 48'h0000_0000_B000, step: 48'h0000_0000_000B, rate: 32'hB};
        set_src(0, pa);
        set_src(1, pb);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            w = exp_win(1'b1, 1'b1);
            wait_done($sformatf("t7_g%0d", g), 200, idx, e);
            check($sformatf("t7_g%0d_idx", g), 64'(idx), 64'(w));
            note_grant(w);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge CLK);
        check("t7_idle", 64'(busy), 64'd0);

        check("never_both_done", 64'(both_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
